// File: rtl/z_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : z_fetch
//  Description : Instruction-fetch unit. Owns the PC, fetches one word per
//                instruction over a req/ack handshake and holds it for decode.
//  Revision    : 1.0  initial release
// ============================================================================
module z_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] next_pc,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    // A misaligned reset vector would fault on the very first fetch.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("z_fetch: RESET_PC must be word-aligned");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_capture;
    logic        w_load_pc;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic [31:0] r_fetch_count;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_load_pc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    w_load_pc    = 1'b1;
                    w_state_next = (next_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0000_0000;
            r_inst_valid  <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            if (w_capture) begin
                r_inst        <= imem_rdata;
                r_inst_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            // The faulting target is still loaded so it stays visible on pc.
            if (w_load_pc) begin
                r_pc         <= next_pc;
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign inst_valid  = r_inst_valid;
    assign fault       = (r_state == S_FAULT);
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_z_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z_fetch
//  Description : Directed scoreboard bench for z_fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] next_pc;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rises  = 0;

    z_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .next_pc     (next_pc),
        .advance     (advance),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Monitor: each new capture must match the oldest expected fetch.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (inst_valid && !prev_valid) begin
            rises++;
            if (exp_q.size() == 0) begin
                check("unexpected_capture", inst, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_inst", inst, e.inst);
                check("sb_count", fetch_count, e.cnt);
            end
        end
        prev_valid = inst_valid;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle();
        check("idle_req", {31'd0, imem_req}, 32'd0);
        check("idle_pc", pc, C_RESET_PC);
        check("idle_valid", {31'd0, inst_valid}, 32'd0);
        check("idle_count", fetch_count, 32'd0);
        check("idle_inst", inst, 32'd0);
        check("idle_fault", {31'd0, fault}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        next_pc    = 32'd0;
        advance    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // IDLE cycle, then FETCH at RESET_PC
        step();
        check_idle();
        step();
        check("fetch0_req", {31'd0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr, C_RESET_PC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        exp_q.push_back('{C_RESET_PC, 32'h2008_0005, 32'd1});

        // HOLD: valid one cycle after ack
        step();
        imem_ack = 1'b0;
        check("lat_valid", {31'd0, inst_valid}, 32'd1);
        check("lat_inst", inst, 32'h2008_0005);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        advance = 1'b1;
        next_pc = 32'h0040_0004;

        // FETCH with three wait cycles
        step();
        advance = 1'b0;
        check("adv_pc", pc, 32'h0040_0004);
        check("adv_count", fetch_count, 32'd1);
        check("adv_valid", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h0040_0004);
            check("wait_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C09_0000;
        exp_q.push_back('{32'h0040_0004, 32'h8C09_0000, 32'd2});

        // Decode stall with a spurious ack
        for (int i = 0; i < 5; i++) begin
            step();
            imem_ack   = (i == 1);
            imem_rdata = 32'hFFFF_FFFF;
            check("stall_inst", inst, 32'h8C09_0000);
            check("stall_pc", pc, 32'h0040_0004);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_count", fetch_count, 32'd2);
            check("stall_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
        advance  = 1'b1;
        next_pc  = 32'h0040_0008;

        step();
        advance    = 1'b0;
        check("f3_req", {31'd0, imem_req}, 32'd1);
        check("f3_addr", imem_addr, 32'h0040_0008);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        exp_q.push_back('{32'h0040_0008, 32'h0000_0020, 32'd3});

        // Misaligned target
        step();
        imem_ack = 1'b0;
        advance  = 1'b1;
        next_pc  = 32'h0040_0006;
        step();
        advance = 1'b0;
        check("fault_set", {31'd0, fault}, 32'd1);
        check("fault_pc", pc, 32'h0040_0006);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            advance  = 1'b1;
            next_pc  = 32'h0040_0010;
            step();
            check("fault_req", {31'd0, imem_req}, 32'd0);
            check("fault_hold", {31'd0, fault}, 32'd1);
            check("fault_pc_hold", pc, 32'h0040_0006);
            check("fault_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack = 1'b0;
        advance  = 1'b0;

        // Reset out of FAULT, then reset during FETCH with ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle();
        step();
        check("rf_req", {31'd0, imem_req}, 32'd1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        rst      = 1'b0;
        imem_ack = 1'b0;
        check_idle();
        step();
        check("rs_req", {31'd0, imem_req}, 32'd1);
        check("rs_addr", imem_addr, C_RESET_PC);
        step();

        check("sb_drained", exp_q.size(), 32'd0);
        check("capture_rises", rises, 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
